vm2002_change_dispenser: RTL and testbench

//  Downstream of the vm2002 vending FSM: takes the balance computed at purchase, returns it
//  as quarters/dimes/nickels through a per-coin valid/ready handshake to the coin ejector.

---
 rtl/vm2002_common_pkg.sv | 33 +++
 rtl/vm2002_coin_tube.sv | 35 +++
 rtl/vm2002_change_dispenser.sv | 141 ++++++++++++++
 tb/tb_vm2002_change_dispenser.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm2002_common_pkg.sv
// Shared vm2002 types: coin encoding, coin values and change-dispenser state.
package vm2002_common_pkg;

   typedef enum logic [1:0] {
      COIN_NONE = 2'd0,
      NICKEL    = 2'd1,
      DIME      = 2'd2,
      QUARTER   = 2'd3
   } coin_t;

   typedef enum logic [1:0] {
      IDLE,
      PICK,
      OFFER,
      FIN
   } changer_state_t;

   localparam logic [4:0] NICKEL_VAL  = 5'd5;
   localparam logic [4:0] DIME_VAL    = 5'd10;
   localparam logic [4:0] QUARTER_VAL = 5'd25;

   function automatic logic [4:0] coin_value(input coin_t c);
      logic [4:0] v;
      case (c)
         NICKEL:  v = NICKEL_VAL;
         DIME:    v = DIME_VAL;
         QUARTER: v = QUARTER_VAL;
         default: v = 5'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/vm2002_coin_tube.sv
// One coin tube: count register with saturating refill, single-coin decrement and empty flag.
module vm2002_coin_tube #(
   parameter int unsigned CNT_W     = 5,
   parameter int unsigned MAX_COINS = 16,
   parameter int unsigned INIT      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             add_en,
   input  logic [CNT_W-1:0] add_cnt,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             empty,
   output logic             ovf
);

   localparam logic [CNT_W:0] MAX_EXT = (CNT_W+1)'(MAX_COINS);

   logic [CNT_W:0] sum;

   assign sum   = {1'b0, cnt} + {1'b0, add_cnt};
   assign ovf   = (sum > MAX_EXT);
   assign empty = (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= CNT_W'(INIT);
      end else if (add_en) begin
         cnt <= ovf ? CNT_W'(MAX_COINS) : sum[CNT_W-1:0];
      end else if (dec && !empty) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/vm2002_change_dispenser.sv
// Returns purchase balance as quarters/dimes/nickels over a per-coin valid/ready handshake,
// tracking one tube per denomination and reporting any amount it cannot pay.
module vm2002_change_dispenser
   import vm2002_common_pkg::*;
#(
   parameter int unsigned AMT_W     = 16,
   parameter int unsigned CNT_W     = 5,
   parameter int unsigned MAX_COINS = 16,
   parameter int unsigned INIT_Q    = 8,
   parameter int unsigned INIT_D    = 8,
   parameter int unsigned INIT_N    = 8
) (
   input  logic             clk,
   input  logic             hrst,
   input  logic             start,
   input  logic [AMT_W-1:0] balance,
   output logic             eject_valid,
   output coin_t            eject_coin,
   input  logic             eject_ready,
   output logic             busy,
   output logic             done,
   output logic             short_pay,
   output logic [AMT_W-1:0] owed,
   input  logic             refill_valid,
   input  coin_t            refill_coin,
   input  logic [CNT_W-1:0] refill_cnt,
   output logic             refill_err,
   output logic [CNT_W-1:0] q_cnt,
   output logic [CNT_W-1:0] d_cnt,
   output logic [CNT_W-1:0] n_cnt
);

   changer_state_t   state;
   logic [AMT_W-1:0] rem;
   logic             refill_ok, accept, refill_err_c, sel_ovf;
   logic             q_empty, d_empty, n_empty;
   logic             q_ovf, d_ovf, n_ovf;

   assign refill_ok = (state == IDLE) && refill_valid;
   assign accept    = (state == OFFER) && eject_valid && eject_ready;

   vm2002_coin_tube #(.CNT_W(CNT_W), .MAX_COINS(MAX_COINS), .INIT(INIT_Q)) u_tube_q (
      .clk(clk), .rst(hrst),
      .add_en(refill_ok && (refill_coin == QUARTER)), .add_cnt(refill_cnt),
      .dec(accept && (eject_coin == QUARTER)),
      .cnt(q_cnt), .empty(q_empty), .ovf(q_ovf)
   );

   vm2002_coin_tube #(.CNT_W(CNT_W), .MAX_COINS(MAX_COINS), .INIT(INIT_D)) u_tube_d (
      .clk(clk), .rst(hrst),
      .add_en(refill_ok && (refill_coin == DIME)), .add_cnt(refill_cnt),
      .dec(accept && (eject_coin == DIME)),
      .cnt(d_cnt), .empty(d_empty), .ovf(d_ovf)
   );

   vm2002_coin_tube #(.CNT_W(CNT_W), .MAX_COINS(MAX_COINS), .INIT(INIT_N)) u_tube_n (
      .clk(clk), .rst(hrst),
      .add_en(refill_ok && (refill_coin == NICKEL)), .add_cnt(refill_cnt),
      .dec(accept && (eject_coin == NICKEL)),
      .cnt(n_cnt), .empty(n_empty), .ovf(n_ovf)
   );

   // Refill is flagged when it lands outside IDLE, names no real coin, or saturates its tube.
   always_comb begin
      sel_ovf      = 1'b0;
      refill_err_c = 1'b0;
      case (refill_coin)
         QUARTER: sel_ovf = q_ovf;
         DIME:    sel_ovf = d_ovf;
         NICKEL:  sel_ovf = n_ovf;
         default: sel_ovf = 1'b0;
      endcase
      if (refill_valid) begin
         if ((state != IDLE) || (refill_coin == COIN_NONE)) refill_err_c = 1'b1;
         else                                               refill_err_c = sel_ovf;
      end
   end

   always_ff @(posedge clk or posedge hrst) begin
      if (hrst) begin
         state       <= IDLE;
         rem         <= '0;
         eject_valid <= 1'b0;
         eject_coin  <= COIN_NONE;
         busy        <= 1'b0;
         done        <= 1'b0;
         short_pay   <= 1'b0;
         owed        <= '0;
         refill_err  <= 1'b0;
      end else begin
         done       <= 1'b0;
         refill_err <= refill_err_c;
         case (state)
            IDLE: begin
               if (start) begin
                  rem       <= balance;
                  short_pay <= 1'b0;
                  owed      <= '0;
                  busy      <= 1'b1;
                  state     <= PICK;
               end
            end
            PICK: begin
               if ((rem >= AMT_W'(QUARTER_VAL)) && !q_empty) begin
                  eject_coin  <= QUARTER;
                  eject_valid <= 1'b1;
                  state       <= OFFER;
               end else if ((rem >= AMT_W'(DIME_VAL)) && !d_empty) begin
                  eject_coin  <= DIME;
                  eject_valid <= 1'b1;
                  state       <= OFFER;
               end else if ((rem >= AMT_W'(NICKEL_VAL)) && !n_empty) begin
                  eject_coin  <= NICKEL;
                  eject_valid <= 1'b1;
                  state       <= OFFER;
               end else begin
                  done  <= 1'b1;
                  state <= FIN;
                  if (rem != '0) begin
                     short_pay <= 1'b1;
                     owed      <= rem;
                  end
               end
            end
            OFFER: begin
               if (eject_ready) begin
                  eject_valid <= 1'b0;
                  rem         <= rem - AMT_W'(coin_value(eject_coin));
                  state       <= PICK;
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Self-checking bench for vm2002_change_dispenser: vector table, directed corner cases, random vs model.
module tb_vm2002_change_dispenser;
   import vm2002_common_pkg::*;

   localparam int unsigned AMT_W = 16;
   localparam int unsigned CNT_W = 5;
   localparam int unsigned MAXC  = 16;
   localparam int unsigned INIT  = 8;

   logic             clk = 1'b0;
   logic             hrst, start, eject_ready, refill_valid;
   logic [AMT_W-1:0] balance, owed;
   coin_t            eject_coin, refill_coin;
   logic             eject_valid, busy, done, short_pay, refill_err;
   logic [CNT_W-1:0] refill_cnt, q_cnt, d_cnt, n_cnt;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   coin_t            got_coins[$];
   logic             got_ok, got_short;
   logic [AMT_W-1:0] got_owed;

   coin_t       exp_coins[$];
   int unsigned exp_owed;
   int unsigned mq, md, mn;

   typedef struct {
      int unsigned bal;
      int unsigned ncoins;
      coin_t       first;
      logic        sp;
      int unsigned ow;
      int unsigned q, d, n;
   } vec_t;
   vec_t vecs[7];

   always #5 clk = ~clk;

   vm2002_change_dispenser #(
      .AMT_W(AMT_W), .CNT_W(CNT_W), .MAX_COINS(MAXC),
      .INIT_Q(INIT), .INIT_D(INIT), .INIT_N(INIT)
   ) dut (
      .clk(clk), .hrst(hrst), .start(start), .balance(balance),
      .eject_valid(eject_valid), .eject_coin(eject_coin), .eject_ready(eject_ready),
      .busy(busy), .done(done), .short_pay(short_pay), .owed(owed),
      .refill_valid(refill_valid), .refill_coin(refill_coin), .refill_cnt(refill_cnt),
      .refill_err(refill_err), .q_cnt(q_cnt), .d_cnt(d_cnt), .n_cnt(n_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      hrst = 1'b1; start = 1'b0; eject_ready = 1'b0; refill_valid = 1'b0;
      refill_coin = COIN_NONE; refill_cnt = '0; balance = '0;
      #3;
      tick();
      hrst = 1'b0;
      tick();
   endtask

   task automatic collect(input int unsigned stall_pct);
      got_coins.delete();
      got_ok = 1'b0; got_short = 1'b0; got_owed = '0;
      for (int cyc = 0; cyc < 400 && !got_ok; cyc++) begin
         eject_ready = ($urandom_range(99) >= stall_pct);
         if (eject_valid && eject_ready) got_coins.push_back(eject_coin);
         tick();
         if (done) begin
            got_ok = 1'b1; got_short = short_pay; got_owed = owed;
         end
      end
      eject_ready = 1'b0;
      check("payout_done_seen", got_ok, 1);
      tick();
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
   endtask

   task automatic do_payout(input int unsigned bal, input int unsigned stall_pct);
      balance = AMT_W'(bal);
      start = 1'b1;
      tick();
      start = 1'b0;
      collect(stall_pct);
   endtask

   task automatic do_refill(input coin_t c, input int unsigned k);
      refill_valid = 1'b1; refill_coin = c; refill_cnt = CNT_W'(k);
      tick();
      refill_valid = 1'b0;
   endtask

   // Greedy payout computed in bulk per denomination.
   task automatic model_pay(input int unsigned bal);
      int unsigned r, k;
      r = bal;
      exp_coins.delete();
      k = r / 25; if (k > mq) k = mq; mq -= k; r -= 25 * k;
      repeat (k) exp_coins.push_back(QUARTER);
      k = r / 10; if (k > md) k = md; md -= k; r -= 10 * k;
      repeat (k) exp_coins.push_back(DIME);
      k = r / 5;  if (k > mn) k = mn; mn -= k; r -= 5 * k;
      repeat (k) exp_coins.push_back(NICKEL);
      exp_owed = r;
   endtask

   function automatic int unsigned model_add(input int unsigned cnt, input int unsigned k);
      return (cnt + k > MAXC) ? MAXC : cnt + k;
   endfunction

   initial begin
      vecs[0] = '{bal: 40,  ncoins: 3,  first: QUARTER,   sp: 1'b0, ow: 0,  q: 7, d: 7, n: 7};
      vecs[1] = '{bal: 0,   ncoins: 0,  first: COIN_NONE, sp: 1'b0, ow: 0,  q: 7, d: 7, n: 7};
      vecs[2] = '{bal: 3,   ncoins: 0,  first: COIN_NONE, sp: 1'b1, ow: 3,  q: 7, d: 7, n: 7};
      vecs[3] = '{bal: 65,  ncoins: 4,  first: QUARTER,   sp: 1'b0, ow: 0,  q: 5, d: 6, n: 6};
      vecs[4] = '{bal: 8,   ncoins: 1,  first: NICKEL,    sp: 1'b1, ow: 3,  q: 5, d: 6, n: 5};
      vecs[5] = '{bal: 200, ncoins: 14, first: QUARTER,   sp: 1'b0, ow: 0,  q: 0, d: 0, n: 2};
      vecs[6] = '{bal: 20,  ncoins: 2,  first: NICKEL,    sp: 1'b1, ow: 10, q: 0, d: 0, n: 0};

      do_reset();
      check("rst_eject_valid", eject_valid, 0);
      check("rst_eject_coin", eject_coin, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_short", short_pay, 0);
      check("rst_owed", owed, 0);
      check("rst_refill_err", refill_err, 0);
      check("rst_tubes", {q_cnt, d_cnt, n_cnt}, {5'd8, 5'd8, 5'd8});

      for (int i = 0; i < 7; i++) begin
         do_payout(vecs[i].bal, 25);
         check("vec_ncoins", got_coins.size(), vecs[i].ncoins);
         check("vec_first", (got_coins.size() > 0) ? got_coins[0] : COIN_NONE, vecs[i].first);
         check("vec_short", got_short, vecs[i].sp);
         check("vec_owed", got_owed, vecs[i].ow);
         check("vec_q", q_cnt, vecs[i].q);
         check("vec_d", d_cnt, vecs[i].d);
         check("vec_n", n_cnt, vecs[i].n);
      end
      check("vec1_order", {got_coins.size() == 2 ? 1'b1 : 1'b0}, 1);

      // No quarters left: 30 must be paid as three dimes.
      do_reset();
      do_payout(200, 0);
      check("q_drain", q_cnt, 0);
      do_payout(30, 0);
      check("dimes_n", got_coins.size(), 3);
      for (int i = 0; i < got_coins.size(); i++) check("dimes_coin", got_coins[i], DIME);
      check("dimes_d", d_cnt, 5);
      check("dimes_short", got_short, 0);

      // No nickels: 15 leaves 5 unpaid.
      do_reset();
      repeat (8) do_payout(5, 0);
      check("n_drain", n_cnt, 0);
      do_payout(15, 0);
      check("nonick_n", got_coins.size(), 1);
      check("nonick_coin", got_coins.size() > 0 ? got_coins[0] : COIN_NONE, DIME);
      check("nonick_short", got_short, 1);
      check("nonick_owed", got_owed, 5);

      // Backpressure holds the offer; start while busy is ignored.
      do_reset();
      balance = 25; start = 1'b1; tick(); start = 1'b0; tick();
      for (int i = 0; i < 10; i++) begin
         check("stall_valid", eject_valid, 1);
         check("stall_coin", eject_coin, QUARTER);
         check("stall_q", q_cnt, 8);
         if (i == 3) begin balance = 100; start = 1'b1; end
         tick();
         start = 1'b0;
      end
      eject_ready = 1'b1; tick(); eject_ready = 1'b0;
      check("stall_q_after", q_cnt, 7);
      collect(0);
      check("stall_extra_coins", got_coins.size(), 0);
      check("stall_short", got_short, 0);
      check("stall_owed", got_owed, 0);
      repeat (3) tick();
      check("busy_start_ignored", {busy, eject_valid, q_cnt}, {2'b00, 5'd7});

      // Refill: saturation, clean add, bad coin, while busy, same cycle as start.
      do_reset();
      do_refill(QUARTER, 12);
      check("refill_sat_err", refill_err, 1);
      check("refill_sat_q", q_cnt, 16);
      tick();
      check("refill_err_pulse", refill_err, 0);
      do_refill(NICKEL, 3);
      check("refill_ok_err", refill_err, 0);
      check("refill_ok_n", n_cnt, 11);
      do_refill(COIN_NONE, 5);
      check("refill_bad_err", refill_err, 1);
      check("refill_bad_tubes", {q_cnt, d_cnt, n_cnt}, {5'd16, 5'd8, 5'd11});
      balance = 10; start = 1'b1; tick(); start = 1'b0;
      do_refill(DIME, 1);
      check("refill_busy_err", refill_err, 1);
      check("refill_busy_d", d_cnt, 8);
      collect(0);
      check("refill_busy_d_after", d_cnt, 7);
      do_payout(400, 0);
      check("q16_drain", {got_coins.size() == 16 ? 1'b1 : 1'b0, q_cnt}, {1'b1, 5'd0});
      refill_valid = 1'b1; refill_coin = QUARTER; refill_cnt = 1;
      balance = 25; start = 1'b1;
      tick();
      refill_valid = 1'b0; start = 1'b0;
      collect(0);
      check("same_cycle_n", got_coins.size(), 1);
      check("same_cycle_coin", got_coins.size() > 0 ? got_coins[0] : COIN_NONE, QUARTER);
      check("same_cycle_short", got_short, 0);

      // Async reset mid-offer restores tubes and drops the coin in flight.
      do_reset();
      balance = 40; start = 1'b1; tick(); start = 1'b0;
      eject_ready = 1'b1;
      repeat (3) tick();
      eject_ready = 1'b0;
      check("pre_rst_offer", {eject_valid, eject_coin, q_cnt}, {1'b1, DIME, 5'd7});
      #2 hrst = 1'b1;
      #1;
      check("async_rst_out", {eject_valid, busy, done, eject_coin}, 5'd0);
      check("async_rst_tubes", {q_cnt, d_cnt, n_cnt}, {5'd8, 5'd8, 5'd8});
      tick(); hrst = 1'b0; tick();
      check("post_rst_idle", {busy, eject_valid}, 2'b00);

      // Random refills and payouts against the bulk model.
      do_reset();
      mq = INIT; md = INIT; mn = INIT;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(1) == 1) begin
            coin_t       c;
            int unsigned k;
            logic        e;
            c = coin_t'($urandom_range(3));
            k = $urandom_range(31);
            e = 1'b1;
            case (c)
               QUARTER: begin e = (mq + k > MAXC); mq = model_add(mq, k); end
               DIME:    begin e = (md + k > MAXC); md = model_add(md, k); end
               NICKEL:  begin e = (mn + k > MAXC); mn = model_add(mn, k); end
               default: e = 1'b1;
            endcase
            do_refill(c, k);
            check("rnd_refill_err", refill_err, e);
            tick();
         end
         begin
            int unsigned b;
            b = $urandom_range(150);
            model_pay(b);
            do_payout(b, 30);
            check("rnd_ncoins", got_coins.size(), exp_coins.size());
            for (int i = 0; i < exp_coins.size() && i < got_coins.size(); i++)
               check("rnd_coin", got_coins[i], exp_coins[i]);
            check("rnd_short", got_short, exp_owed != 0);
            check("rnd_owed", got_owed, exp_owed);
            check("rnd_tubes", {q_cnt, d_cnt, n_cnt}, {CNT_W'(mq), CNT_W'(md), CNT_W'(mn)});
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
